bits_smem_arbiter: RTL and testbench
====================================

Name: bits_smem_arbiter

Overview:
Arbitrates the single-port stack memory (14-bit address, 96-bit word, active-low ceb/web, 1-cycle read latency) between two requesters: the core FSM and a host/debug port driven from bits_regs.
The core has fixed priority. A starvation guard forces one host grant, stalling the core, after MAX_WAIT contended cycles.
The block sits between bits_fsm and the stack SRAM. It lets software inspect or patch stack contents while a decode is running.

Parameters:
MAX_WAIT, 8, contended host-pending cycles before a forced host grant (range 1..255)
DEPTH, 16384, number of implemented stack words; host addresses >= DEPTH are rejected

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
core_ceb  input  1  core chip enable, active low
core_web  input  1  core write enable, active low (meaningful only when core_ceb=0)
core_addr  input  14  core address
core_wdata  input  96  core write data
core_rdata  output  96  core read data; combinational pass-through of smem_rdata
core_stall  output  1  core access not performed this cycle; core must hold its request
host_req  input  1  host request, level; held until host_ack
host_web  input  1  host write enable, active low
host_addr  input  14  host address
host_wdata  input  96  host write data
host_ack  output  1  one-cycle completion pulse
host_err  output  1  valid with host_ack; 1 = address out of range, no access made
host_rdata  output  96  registered read data; held until the next host read completes
smem_ceb  output  1  SRAM chip enable, active low
smem_web  output  1  SRAM write enable, active low
smem_addr  output  14  SRAM address
smem_wdata  output  96  SRAM write data
smem_rdata  input  96  SRAM read data, valid the cycle after a read access
stall_count  output  16  saturating count of cycles with core_stall=1

Behaviour:
- Reset values:
  - smem_ceb=1, smem_web=1; smem_addr and smem_wdata are 0.
  - host_ack=0, host_err=0, host_rdata=0, core_stall=0, stall_count=0.
  - wait_cnt=0, state=IDLE.
- States:
  - IDLE: no host transaction outstanding.
  - RD_WAIT: host read issued last cycle.
  - ACK: host_ack pulse.
  - REL: waiting for host_req to fall.
- Host grant condition: state=IDLE, host_req=1, address in range, and either core_ceb=1 or wait_cnt==MAX_WAIT.
- Grant cycle G (combinational mux):
  - smem_* carry the host signals.
  - If core_ceb=0 in G, core_stall=1 and the core access is dropped.
- Memory mux outside a host grant: smem_* = core_* (combinational, zero added latency); core_stall=0.
- Host write timing:
  - G: SRAM write.
  - G+1: state ACK, host_ack=1.
  - G+2: state REL.
- Host read timing:
  - G: SRAM read.
  - G+1: state RD_WAIT; host_rdata <= smem_rdata at the end of the cycle.
  - G+2: ACK, host_ack=1 with host_rdata stable.
  - G+3: REL.
- Out-of-range host address (host_addr >= DEPTH) in IDLE:
  - No SRAM access; the core is not stalled.
  - Next cycle: ACK with host_ack=1, host_err=1.
  - host_err=0 on every in-range ack.
- REL: return to IDLE in the first cycle host_req=0. A host_req held high after ack never causes a second transaction.
- wait_cnt:
  - Increments in IDLE while host_req=1 and core_ceb=0 and no grant is made.
  - Saturates at MAX_WAIT.
  - Clears on grant and whenever host_req=0.
- Forced grant affects exactly one cycle. The core's held request is serviced in G+1 (the core wins G+1 because the host is no longer in IDLE).
- stall_count increments on each core_stall=1 cycle and saturates at 16'hFFFF.
- Reset asserted mid-transaction: immediate return to reset values; the pending host transaction is abandoned with no ack.

Decomposition:
- Shared package bits_pkg:
  - SMEM_AW=14, SMEM_DW=96.
  - State encoding: IDLE=2'd0, RD_WAIT=2'd1, ACK=2'd2, REL=2'd3.
  - The core and host request-bundle typedefs.
- No sub-module: the mux, the FSM and the two counters fit in one module.

Test Plan:
- Idle core, host write addr 14'h0010, data 96'hA5…: smem_ceb=0 and smem_web=0 in G → host_ack at G+1, host_err=0, stall_count=0.
- Core idle, host read of 14'h0010 after the write above → host_ack at G+2, host_rdata=96'hA5…; host_rdata holds after ack.
- Core reading continuously, host_req held, MAX_WAIT=8 → grant on the 9th pending cycle, core_stall=1 for exactly 1 cycle, stall_count=1, core access completes next cycle.
- DEPTH=12288, host read at 14'h3000 → host_ack at the cycle after request, host_err=1, smem_ceb driven only by the core, no core stall.
- host_req kept high for 10 cycles after ack → exactly one transaction; drop host_req, reassert → second transaction granted.
- Reset pulsed in RD_WAIT → host_ack never asserted, smem_ceb=1, stall_count=0; the next host read completes normally.

Source files
------------

// File: rtl/bits_pkg.sv
// Shared types and constants for the bits stack-memory path.
// Used by the stack arbiter and by anything that talks to the stack SRAM.
package bits_pkg;

  localparam int SMEM_AW = 14;
  localparam int SMEM_DW = 96;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2,
    REL     = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic               ceb;
    logic               web;
    logic [SMEM_AW-1:0] addr;
    logic [SMEM_DW-1:0] wdata;
  } core_req_t;

  typedef struct packed {
    logic               req;
    logic               web;
    logic [SMEM_AW-1:0] addr;
    logic [SMEM_DW-1:0] wdata;
  } host_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bits_smem_arbiter.sv
// Stack SRAM arbiter: core has fixed priority, host/debug port gets a forced
// single-cycle grant once it has waited MAX_WAIT contended cycles.
module bits_smem_arbiter
  import bits_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int DEPTH    = 16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               core_ceb,
  input  logic               core_web,
  input  logic [SMEM_AW-1:0] core_addr,
  input  logic [SMEM_DW-1:0] core_wdata,
  output logic [SMEM_DW-1:0] core_rdata,
  output logic               core_stall,
  input  logic               host_req,
  input  logic               host_web,
  input  logic [SMEM_AW-1:0] host_addr,
  input  logic [SMEM_DW-1:0] host_wdata,
  output logic               host_ack,
  output logic               host_err,
  output logic [SMEM_DW-1:0] host_rdata,
  output logic               smem_ceb,
  output logic               smem_web,
  output logic [SMEM_AW-1:0] smem_addr,
  output logic [SMEM_DW-1:0] smem_wdata,
  input  logic [SMEM_DW-1:0] smem_rdata,
  output logic [15:0]        stall_count
);

  localparam logic [7:0]       MAX_WAIT_L = 8'(MAX_WAIT);
  localparam logic [SMEM_AW:0] DEPTH_L    = 15'(DEPTH);

  core_req_t          core_s;
  host_req_t          host_s;
  arb_state_e         state_r;
  arb_state_e         state_nxt_s;
  logic [7:0]         wait_cnt_r;
  logic               err_r;
  logic [SMEM_DW-1:0] host_rdata_r;
  logic [15:0]        stall_count_r;
  logic               in_range_s;
  logic               pending_s;
  logic               grant_s;
  logic               reject_s;
  logic               core_stall_s;

  assign core_s = '{ceb: core_ceb, web: core_web, addr: core_addr, wdata: core_wdata};
  assign host_s = '{req: host_req, web: host_web, addr: host_addr, wdata: host_wdata};

  // Grant decision for a host request waiting in IDLE.
  always_comb begin
    in_range_s   = ({1'b0, host_s.addr} < DEPTH_L);
    pending_s    = (state_r == IDLE) && host_s.req && !reset;
    grant_s      = pending_s && in_range_s && (core_s.ceb || (wait_cnt_r == MAX_WAIT_L));
    reject_s     = pending_s && !in_range_s;
    core_stall_s = grant_s && !core_s.ceb;
  end

  // SRAM port mux; the core passes straight through unless the host holds the grant.
  always_comb begin
    smem_ceb   = 1'b1;
    smem_web   = 1'b1;
    smem_addr  = '0;
    smem_wdata = '0;
    if (reset) begin
      smem_ceb   = 1'b1;
      smem_web   = 1'b1;
      smem_addr  = '0;
      smem_wdata = '0;
    end else if (grant_s) begin
      smem_ceb   = 1'b0;
      smem_web   = host_s.web;
      smem_addr  = host_s.addr;
      smem_wdata = host_s.wdata;
    end else begin
      smem_ceb   = core_s.ceb;
      smem_web   = core_s.web;
      smem_addr  = core_s.addr;
      smem_wdata = core_s.wdata;
    end
  end

  // Host transaction sequencing.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s = host_s.web ? RD_WAIT : ACK;
        end else if (reject_s) begin
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_WAIT: state_nxt_s = ACK;
      ACK:     state_nxt_s = REL;
      REL: begin
        if (host_s.req) begin
          state_nxt_s = REL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, error flag and captured host read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      err_r        <= 1'b0;
      host_rdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        err_r <= 1'b0;
      end else if (reject_s) begin
        err_r <= 1'b1;
      end
      if (state_r == RD_WAIT) begin
        host_rdata_r <= smem_rdata;
      end
    end
  end

  // Contended-wait counter feeding the starvation guard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
    end else if (!host_s.req || grant_s || reject_s) begin
      wait_cnt_r <= 8'd0;
    end else if (pending_s && !core_s.ceb && (wait_cnt_r != MAX_WAIT_L)) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end
  end

  // Saturating count of core stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_r <= 16'd0;
    end else if (core_stall_s) begin
      stall_count_r <= sat_inc16(stall_count_r);
    end
  end

  assign core_rdata  = smem_rdata;
  assign core_stall  = core_stall_s;
  assign host_ack    = (state_r == ACK);
  assign host_err    = (state_r == ACK) && err_r;
  assign host_rdata  = host_rdata_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_bits_smem_arbiter.sv
// Self-checking bench for bits_smem_arbiter: SRAM model, transaction-level
// reference model checked every cycle, and directed host/core scenarios.
module tb_bits_smem_arbiter;

  localparam int MAX_WAIT_TB = 8;
  localparam int DEPTH_TB    = 12288;
  localparam logic [95:0] PAT_A5 = {12{8'hA5}};
  localparam logic [95:0] PAT_5A = {12{8'h5A}};
  localparam logic [95:0] PAT_C3 = {12{8'hC3}};

  logic        clk = 1'b0;
  logic        reset;
  logic        core_ceb, core_web, host_req, host_web;
  logic [13:0] core_addr, host_addr;
  logic [95:0] core_wdata, host_wdata, core_rdata, host_rdata;
  logic        core_stall, host_ack, host_err;
  logic        smem_ceb, smem_web;
  logic [13:0] smem_addr;
  logic [95:0] smem_wdata, smem_rdata;
  logic [15:0] stall_count;

  int n_pass = 0;
  int n_total = 0;

  bits_smem_arbiter #(.MAX_WAIT(MAX_WAIT_TB), .DEPTH(DEPTH_TB)) dut (
    .clk(clk), .reset(reset),
    .core_ceb(core_ceb), .core_web(core_web), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_web(host_web), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_err(host_err),
    .host_rdata(host_rdata),
    .smem_ceb(smem_ceb), .smem_web(smem_web), .smem_addr(smem_addr),
    .smem_wdata(smem_wdata), .smem_rdata(smem_rdata), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, contents survive reset.
  bit [95:0] sram [0:16383];
  bit [95:0] sram_q;
  assign smem_rdata = sram_q;
  always @(posedge clk) begin
    if (!smem_ceb) begin
      if (!smem_web) sram[smem_addr] <= smem_wdata;
      else sram_q <= sram[smem_addr];
    end
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model state (transaction level).
  bit [95:0]   shadow [0:16383];
  int          cyc = 0;
  int          ack_at = -1;
  int          rd_from = -1;
  bit          ack_err;
  bit          busy = 1'b0;
  int          pend = 0;
  logic [95:0] rd_val;
  logic [95:0] exp_hrdata = '0;
  int          exp_scnt = 0;
  int          stall_seen = 0;
  int          ack_seen = 0;

  always @(negedge clk) begin
    logic        e_ceb, e_web, e_stall, e_ack, e_err;
    logic [13:0] e_addr;
    logic [95:0] e_wd;
    cyc++;
    if (reset) begin
      busy = 1'b0; pend = 0; ack_at = -1; rd_from = -1; exp_hrdata = '0; exp_scnt = 0;
      chk("rst_smem_ceb", smem_ceb, 1'b1);
      chk("rst_smem_web", smem_web, 1'b1);
      chk("rst_smem_addr", smem_addr, 14'd0);
      chk("rst_smem_wdata", smem_wdata, 96'd0);
      chk("rst_host_ack", host_ack, 1'b0);
      chk("rst_host_err", host_err, 1'b0);
      chk("rst_host_rdata", host_rdata, 96'd0);
      chk("rst_core_stall", core_stall, 1'b0);
      chk("rst_stall_count", stall_count, 16'd0);
    end else begin
      e_ceb = core_ceb; e_web = core_web; e_addr = core_addr; e_wd = core_wdata; e_stall = 1'b0;
      if (!busy && host_req) begin
        if (int'(host_addr) >= DEPTH_TB) begin
          busy = 1'b1; ack_at = cyc + 1; ack_err = 1'b1; pend = 0;
        end else if (core_ceb || pend == MAX_WAIT_TB) begin
          e_ceb = 1'b0; e_web = host_web; e_addr = host_addr; e_wd = host_wdata;
          e_stall = !core_ceb; busy = 1'b1; pend = 0; ack_err = 1'b0;
          if (host_web) begin
            ack_at = cyc + 2; rd_from = cyc + 2; rd_val = shadow[host_addr];
          end else begin
            ack_at = cyc + 1;
          end
        end else begin
          pend++;
        end
      end else if (!host_req) begin
        pend = 0;
      end
      e_ack = (cyc == ack_at);
      e_err = e_ack && ack_err;
      if (cyc == rd_from) exp_hrdata = rd_val;
      chk("smem_ceb", smem_ceb, e_ceb);
      chk("smem_web", smem_web, e_web);
      chk("smem_addr", smem_addr, e_addr);
      chk("smem_wdata", smem_wdata, e_wd);
      chk("core_stall", core_stall, e_stall);
      chk("host_ack", host_ack, e_ack);
      chk("host_err", host_err, e_err);
      chk("host_rdata", host_rdata, exp_hrdata);
      chk("stall_count", stall_count, 16'(exp_scnt));
      chk("core_rdata", core_rdata, smem_rdata);
      if (!e_ceb && !e_web) shadow[e_addr] = e_wd;
      if (e_stall && exp_scnt < 65535) exp_scnt++;
      if (busy && cyc > ack_at && !host_req) busy = 1'b0;
    end
    if (host_ack) ack_seen++;
    if (core_stall) stall_seen++;
  end

  task automatic host_txn(input logic web, input logic [13:0] a, input logic [95:0] d,
                          input int hold, output int lat, output logic err, output logic [95:0] rd);
    host_req = 1'b1; host_web = web; host_addr = a; host_wdata = d; lat = 0;
    @(negedge clk);
    while (!host_ack && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    if (!host_ack) chk("ack_timeout", host_ack, 1'b1);
    err = host_err; rd = host_rdata;
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 host_req = 1'b0; host_web = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, a0;
    logic        err;
    logic [95:0] rd;
    reset = 1'b1; core_ceb = 1'b1; core_web = 1'b1; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_web = 1'b1; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Idle core: host write then read back.
    host_txn(1'b0, 14'h0010, PAT_A5, 0, lat, err, rd);
    chk("wr_latency", lat, 1);
    chk("wr_err", err, 1'b0);
    chk("wr_stall_count", stall_count, 16'd0);
    host_txn(1'b1, 14'h0010, '0, 0, lat, err, rd);
    chk("rd_latency", lat, 2);
    chk("rd_err", err, 1'b0);
    chk("rd_data", rd, PAT_A5);
    repeat (3) @(posedge clk); #1;
    chk("rd_hold", host_rdata, PAT_A5);

    // Core reading continuously: forced grant after MAX_WAIT contended cycles.
    core_ceb = 1'b0; core_web = 1'b1; core_addr = 14'h0010;
    host_txn(1'b0, 14'h0030, PAT_5A, 0, lat, err, rd);
    chk("forced_latency", lat, 9);
    chk("forced_stall_cycles", stall_seen, 1);
    chk("forced_stall_count", stall_count, 16'd1);

    // Out-of-range host read while core keeps reading.
    host_txn(1'b1, 14'h3000, '0, 0, lat, err, rd);
    chk("oor_latency", lat, 1);
    chk("oor_err", err, 1'b1);
    chk("oor_no_stall", stall_seen, 1);
    core_ceb = 1'b1;

    // Last implemented word is in range.
    host_txn(1'b1, 14'h2FFF, '0, 0, lat, err, rd);
    chk("edge_latency", lat, 2);
    chk("edge_err", err, 1'b0);
    chk("edge_data", rd, 96'd0);

    // host_req held after ack: exactly one transaction, then a fresh one.
    a0 = ack_seen;
    host_txn(1'b0, 14'h0040, PAT_C3, 10, lat, err, rd);
    chk("held_one_ack", ack_seen - a0, 1);
    host_txn(1'b1, 14'h0040, '0, 0, lat, err, rd);
    chk("second_latency", lat, 2);
    chk("second_data", rd, PAT_C3);
    chk("forced_write_data", shadow[14'h0030], PAT_5A);

    // Reset while the host read is in RD_WAIT.
    host_req = 1'b1; host_web = 1'b1; host_addr = 14'h0010;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b1; host_req = 1'b0;
    a0 = ack_seen;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_ack", ack_seen - a0, 0);
    chk("rst_smem_idle", smem_ceb, 1'b1);
    chk("rst_stall_cleared", stall_count, 16'd0);
    @(posedge clk); #1;
    host_txn(1'b1, 14'h0010, '0, 0, lat, err, rd);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_data", rd, PAT_A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
